// File: rtl/issue_queue.sv
// Unified reservation station: dual dispatch, speculative shift-register wakeup, single issue.
// Optional IQ_AGE_SELECT_EN selects the oldest ready entry instead of the lowest index.
module issue_queue #(
    parameter int ENTRIES   = 8,
    parameter int TAG_W     = 6,
    parameter int LAT_W     = 4,
    parameter int PAYLOAD_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      kill,
    input  logic                      disp_valid_1,
    input  logic                      disp_valid_2,
    input  logic [PAYLOAD_W-1:0]      disp_payload_1,
    input  logic [PAYLOAD_W-1:0]      disp_payload_2,
    input  logic [TAG_W-1:0]          disp_dst_1,
    input  logic [TAG_W-1:0]          disp_dst_2,
    input  logic                      disp_wr_reg_1,
    input  logic                      disp_wr_reg_2,
    input  logic [TAG_W-1:0]          disp_src1_1,
    input  logic [TAG_W-1:0]          disp_src1_2,
    input  logic [TAG_W-1:0]          disp_src2_1,
    input  logic [TAG_W-1:0]          disp_src2_2,
    input  logic                      disp_use1_1,
    input  logic                      disp_use1_2,
    input  logic                      disp_use2_1,
    input  logic                      disp_use2_2,
    input  logic                      disp_match1_1,
    input  logic                      disp_match1_2,
    input  logic                      disp_match2_1,
    input  logic                      disp_match2_2,
    input  logic [LAT_W-1:0]          disp_shift1_1,
    input  logic [LAT_W-1:0]          disp_shift1_2,
    input  logic [LAT_W-1:0]          disp_shift2_1,
    input  logic [LAT_W-1:0]          disp_shift2_2,
    input  logic [LAT_W-1:0]          disp_delay1_1,
    input  logic [LAT_W-1:0]          disp_delay1_2,
    input  logic [LAT_W-1:0]          disp_delay2_1,
    input  logic [LAT_W-1:0]          disp_delay2_2,
    input  logic                      bc_valid_1,
    input  logic                      bc_valid_2,
    input  logic [TAG_W-1:0]          bc_dst_1,
    input  logic [TAG_W-1:0]          bc_dst_2,
    input  logic                      issue_ready,
    output logic                      issue_valid,
    output logic [PAYLOAD_W-1:0]      issue_payload,
    output logic [TAG_W-1:0]          issue_dst,
    output logic                      issue_wr_reg,
    output logic                      own_bc_valid,
    output logic [TAG_W-1:0]          own_bc_dst,
    output logic [$clog2(ENTRIES):0]  free_cnt,
    output logic                      ovf
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [ENTRIES-1:0]   r_valid;
    logic [ENTRIES-1:0]   r_wr_reg;
    logic [PAYLOAD_W-1:0] r_payload [ENTRIES];
    logic [TAG_W-1:0]     r_dst     [ENTRIES];
    logic [TAG_W-1:0]     r_tag     [ENTRIES][2];
    logic                 r_match   [ENTRIES][2];
    logic [LAT_W-1:0]     r_shift   [ENTRIES][2];
    logic [LAT_W-1:0]     r_delay   [ENTRIES][2];
    logic                 r_ovf;

    // Dispatch fields regrouped as [port][source]
    logic                 w_d_valid   [2];
    logic [PAYLOAD_W-1:0] w_d_payload [2];
    logic [TAG_W-1:0]     w_d_dst     [2];
    logic                 w_d_wr      [2];
    logic                 w_d_use     [2][2];
    logic [TAG_W-1:0]     w_d_tag     [2][2];
    logic                 w_d_match   [2][2];
    logic [LAT_W-1:0]     w_d_shift   [2][2];
    logic [LAT_W-1:0]     w_d_delay   [2][2];
    logic                 w_c_match   [2][2];
    logic [LAT_W-1:0]     w_c_shift   [2][2];
    logic [LAT_W-1:0]     w_c_delay   [2][2];

    assign w_d_valid[0] = disp_valid_1;      assign w_d_valid[1] = disp_valid_2;
    assign w_d_payload[0] = disp_payload_1;  assign w_d_payload[1] = disp_payload_2;
    assign w_d_dst[0] = disp_dst_1;          assign w_d_dst[1] = disp_dst_2;
    assign w_d_wr[0] = disp_wr_reg_1;        assign w_d_wr[1] = disp_wr_reg_2;
    assign w_d_use[0][0] = disp_use1_1;      assign w_d_use[0][1] = disp_use2_1;
    assign w_d_use[1][0] = disp_use1_2;      assign w_d_use[1][1] = disp_use2_2;
    assign w_d_tag[0][0] = disp_src1_1;      assign w_d_tag[0][1] = disp_src2_1;
    assign w_d_tag[1][0] = disp_src1_2;      assign w_d_tag[1][1] = disp_src2_2;
    assign w_d_match[0][0] = disp_match1_1;  assign w_d_match[0][1] = disp_match2_1;
    assign w_d_match[1][0] = disp_match1_2;  assign w_d_match[1][1] = disp_match2_2;
    assign w_d_shift[0][0] = disp_shift1_1;  assign w_d_shift[0][1] = disp_shift2_1;
    assign w_d_shift[1][0] = disp_shift1_2;  assign w_d_shift[1][1] = disp_shift2_2;
    assign w_d_delay[0][0] = disp_delay1_1;  assign w_d_delay[0][1] = disp_delay2_1;
    assign w_d_delay[1][0] = disp_delay1_2;  assign w_d_delay[1][1] = disp_delay2_2;

    function automatic logic f_tag_hit(input logic [TAG_W-1:0] tag,
                                       input logic v1, input logic [TAG_W-1:0] t1,
                                       input logic v2, input logic [TAG_W-1:0] t2,
                                       input logic v3, input logic [TAG_W-1:0] t3);
        return (v1 && (t1 == tag)) || (v2 && (t2 == tag)) || (v3 && (t3 == tag));
    endfunction

    logic [ENTRIES-1:0] w_ready;
    logic [IDX_W-1:0]   w_sel;
    logic               w_sel_vld;
    logic               w_fire;
    logic               w_own_v;
    logic [TAG_W-1:0]   w_own_t;

    // Entry is ready once both sources have shift[0] set
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_ready[i] = r_valid[i] & r_shift[i][0][0] & r_shift[i][1][0];
        end
    end

`ifdef IQ_AGE_SELECT_EN
    // r_older[j][i] set means entry j was allocated before entry i
    logic [ENTRIES-1:0] r_older [ENTRIES];

    // Oldest ready entry: ready and no other ready entry is older
    always_comb begin
        logic blk;
        w_sel     = '0;
        w_sel_vld = 1'b0;
        blk       = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            blk = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                blk = blk | ((j != i) && w_ready[j] && r_older[j][i]);
            end
            w_sel     = (w_ready[i] && !blk) ? IDX_W'(i) : w_sel;
            w_sel_vld = w_sel_vld | (w_ready[i] && !blk);
        end
    end
`else
    // Lowest-index ready entry wins
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_sel     = w_ready[i] ? IDX_W'(i) : w_sel;
            w_sel_vld = w_sel_vld | w_ready[i];
        end
    end
`endif

    assign w_fire        = w_sel_vld & issue_ready;
    assign w_own_v       = w_fire & r_wr_reg[w_sel];
    assign w_own_t       = r_dst[w_sel];
    assign issue_valid   = w_sel_vld;
    assign issue_payload = w_sel_vld ? r_payload[w_sel] : '0;
    assign issue_dst     = w_sel_vld ? r_dst[w_sel] : '0;
    assign issue_wr_reg  = w_sel_vld & r_wr_reg[w_sel];
    assign own_bc_valid  = w_own_v;
    assign own_bc_dst    = w_sel_vld ? w_own_t : '0;
    assign ovf           = r_ovf;

    // Free count from registered state only
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_cnt = free_cnt + CNT_W'(!r_valid[i]);
        end
    end

    logic [ENTRIES-1:0] w_free;
    logic [ENTRIES-1:0] w_free_b;
    logic               w_has_a;
    logic               w_has_b;
    logic [IDX_W-1:0]   w_idx_a;
    logic [IDX_W-1:0]   w_idx_b;
    logic               w_take [2];
    logic [IDX_W-1:0]   w_aidx [2];
    logic               w_drop;

    // Two lowest free slots; the entry issuing this cycle counts as free
    always_comb begin
        w_free = ~r_valid;
        w_free[w_sel] = w_free[w_sel] | w_fire;
        w_has_a = 1'b0;
        w_idx_a = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_idx_a = w_free[i] ? IDX_W'(i) : w_idx_a;
            w_has_a = w_has_a | w_free[i];
        end
        w_free_b = w_free;
        w_free_b[w_idx_a] = 1'b0;
        w_has_b = 1'b0;
        w_idx_b = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_idx_b = w_free_b[i] ? IDX_W'(i) : w_idx_b;
            w_has_b = w_has_b | w_free_b[i];
        end
        w_take[0] = disp_valid_1 & w_has_a & !kill;
        w_aidx[0] = w_idx_a;
        w_take[1] = disp_valid_2 & (disp_valid_1 ? w_has_b : w_has_a) & !kill;
        w_aidx[1] = disp_valid_1 ? w_idx_b : w_idx_a;
        w_drop    = !kill & ((disp_valid_1 & !w_has_a) |
                             (disp_valid_2 & !(disp_valid_1 ? w_has_b : w_has_a)));
    end

    // Source capture: unused -> always ready, same-cycle broadcast -> start countdown
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 2; s++) begin
                if (!w_d_use[p][s]) begin
                    w_c_match[p][s] = 1'b1;
                    w_c_shift[p][s] = '1;
                    w_c_delay[p][s] = '1;
                end else if (f_tag_hit(w_d_tag[p][s], bc_valid_1, bc_dst_1,
                                       bc_valid_2, bc_dst_2, 1'b0, '0)) begin
                    w_c_match[p][s] = 1'b1;
                    w_c_shift[p][s] = w_d_delay[p][s];
                    w_c_delay[p][s] = w_d_delay[p][s];
                end else begin
                    w_c_match[p][s] = w_d_match[p][s];
                    w_c_shift[p][s] = w_d_shift[p][s];
                    w_c_delay[p][s] = w_d_delay[p][s];
                end
            end
        end
    end

    // Entry state: wakeup, issue free, dispatch write, flush, overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_ovf   <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (f_tag_hit(r_tag[i][s], bc_valid_1, bc_dst_1, bc_valid_2, bc_dst_2,
                                  w_own_v, w_own_t)) begin
                        r_match[i][s] <= 1'b1;
                        r_shift[i][s] <= r_delay[i][s];
                    end else if (r_match[i][s] && !r_shift[i][s][0]) begin
                        r_shift[i][s] <= {r_shift[i][s][LAT_W-1], r_shift[i][s][LAT_W-1:1]};
                    end
                end
            end
            if (w_fire) begin
                r_valid[w_sel] <= 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (w_take[p]) begin
                    r_valid[w_aidx[p]]   <= 1'b1;
                    r_payload[w_aidx[p]] <= w_d_payload[p];
                    r_dst[w_aidx[p]]     <= w_d_dst[p];
                    r_wr_reg[w_aidx[p]]  <= w_d_wr[p];
                    for (int s = 0; s < 2; s++) begin
                        r_tag[w_aidx[p]][s]   <= w_d_tag[p][s];
                        r_match[w_aidx[p]][s] <= w_c_match[p][s];
                        r_shift[w_aidx[p]][s] <= w_c_shift[p][s];
                        r_delay[w_aidx[p]][s] <= w_c_delay[p][s];
                    end
                end
            end
            if (kill) begin
                r_valid <= '0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef IQ_AGE_SELECT_EN
    // New entry is younger than everything; port 2 written last so port 1 stays older
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_take[p]) begin
                    for (int j = 0; j < ENTRIES; j++) begin
                        r_older[w_aidx[p]][j] <= 1'b0;
                        r_older[j][w_aidx[p]] <= 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a payload scoreboard checked at every issue.
module tb_issue_queue;
    logic        clk = 1'b0;
    logic        reset, kill;
    logic        disp_valid_1, disp_valid_2;
    logic [31:0] disp_payload_1, disp_payload_2;
    logic [5:0]  disp_dst_1, disp_dst_2;
    logic        disp_wr_reg_1, disp_wr_reg_2;
    logic [5:0]  disp_src1_1, disp_src1_2, disp_src2_1, disp_src2_2;
    logic        disp_use1_1, disp_use1_2, disp_use2_1, disp_use2_2;
    logic        disp_match1_1, disp_match1_2, disp_match2_1, disp_match2_2;
    logic [3:0]  disp_shift1_1, disp_shift1_2, disp_shift2_1, disp_shift2_2;
    logic [3:0]  disp_delay1_1, disp_delay1_2, disp_delay2_1, disp_delay2_2;
    logic        bc_valid_1, bc_valid_2;
    logic [5:0]  bc_dst_1, bc_dst_2;
    logic        issue_ready;
    logic        issue_valid, issue_wr_reg, own_bc_valid, ovf;
    logic [31:0] issue_payload;
    logic [5:0]  issue_dst, own_bc_dst;
    logic [3:0]  free_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    issue_queue #(.ENTRIES(8), .TAG_W(6), .LAT_W(4), .PAYLOAD_W(32)) dut (
        .clk(clk), .reset(reset), .kill(kill),
        .disp_valid_1(disp_valid_1), .disp_valid_2(disp_valid_2),
        .disp_payload_1(disp_payload_1), .disp_payload_2(disp_payload_2),
        .disp_dst_1(disp_dst_1), .disp_dst_2(disp_dst_2),
        .disp_wr_reg_1(disp_wr_reg_1), .disp_wr_reg_2(disp_wr_reg_2),
        .disp_src1_1(disp_src1_1), .disp_src1_2(disp_src1_2),
        .disp_src2_1(disp_src2_1), .disp_src2_2(disp_src2_2),
        .disp_use1_1(disp_use1_1), .disp_use1_2(disp_use1_2),
        .disp_use2_1(disp_use2_1), .disp_use2_2(disp_use2_2),
        .disp_match1_1(disp_match1_1), .disp_match1_2(disp_match1_2),
        .disp_match2_1(disp_match2_1), .disp_match2_2(disp_match2_2),
        .disp_shift1_1(disp_shift1_1), .disp_shift1_2(disp_shift1_2),
        .disp_shift2_1(disp_shift2_1), .disp_shift2_2(disp_shift2_2),
        .disp_delay1_1(disp_delay1_1), .disp_delay1_2(disp_delay1_2),
        .disp_delay2_1(disp_delay2_1), .disp_delay2_2(disp_delay2_2),
        .bc_valid_1(bc_valid_1), .bc_valid_2(bc_valid_2),
        .bc_dst_1(bc_dst_1), .bc_dst_2(bc_dst_2),
        .issue_ready(issue_ready), .issue_valid(issue_valid),
        .issue_payload(issue_payload), .issue_dst(issue_dst), .issue_wr_reg(issue_wr_reg),
        .own_bc_valid(own_bc_valid), .own_bc_dst(own_bc_dst),
        .free_cnt(free_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, {31'd0, issue_valid}, 32'd1);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, issue_payload);
        end else begin
            e = exp_q.pop_front();
            assert (issue_payload === e) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, issue_payload, e);
            end
        end
    endtask

    task automatic clr();
        kill = 1'b0;
        disp_valid_1 = 1'b0; disp_valid_2 = 1'b0;
        disp_payload_1 = 32'd0; disp_payload_2 = 32'd0;
        disp_dst_1 = 6'd0; disp_dst_2 = 6'd0;
        disp_wr_reg_1 = 1'b0; disp_wr_reg_2 = 1'b0;
        disp_src1_1 = 6'd0; disp_src1_2 = 6'd0; disp_src2_1 = 6'd0; disp_src2_2 = 6'd0;
        disp_use1_1 = 1'b0; disp_use1_2 = 1'b0; disp_use2_1 = 1'b0; disp_use2_2 = 1'b0;
        disp_match1_1 = 1'b0; disp_match1_2 = 1'b0; disp_match2_1 = 1'b0; disp_match2_2 = 1'b0;
        disp_shift1_1 = 4'd0; disp_shift1_2 = 4'd0; disp_shift2_1 = 4'd0; disp_shift2_2 = 4'd0;
        disp_delay1_1 = 4'd0; disp_delay1_2 = 4'd0; disp_delay2_1 = 4'd0; disp_delay2_2 = 4'd0;
        bc_valid_1 = 1'b0; bc_valid_2 = 1'b0; bc_dst_1 = 6'd0; bc_dst_2 = 6'd0;
    endtask

    // Port p dispatch; source 1 configurable, source 2 unused
    task automatic set_disp(input int p, input logic [31:0] pl, input logic [5:0] dst,
                            input logic wr, input logic use_s, input logic [5:0] tag,
                            input logic m, input logic [3:0] sh, input logic [3:0] dl);
        if (p == 1) begin
            disp_valid_1 = 1'b1; disp_payload_1 = pl; disp_dst_1 = dst; disp_wr_reg_1 = wr;
            disp_use1_1 = use_s; disp_src1_1 = tag; disp_match1_1 = m;
            disp_shift1_1 = sh; disp_delay1_1 = dl;
        end else begin
            disp_valid_2 = 1'b1; disp_payload_2 = pl; disp_dst_2 = dst; disp_wr_reg_2 = wr;
            disp_use1_2 = use_s; disp_src1_2 = tag; disp_match1_2 = m;
            disp_shift1_2 = sh; disp_delay1_2 = dl;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        clr();
        issue_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        chk("rst_free", 32'(free_cnt), 32'd8);
        chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_own_bc", {31'd0, own_bc_valid}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_payload", issue_payload, 32'd0);
        chk("rst_dst", 32'(issue_dst), 32'd0);

        // single dispatch, no sources used
        set_disp(1, 32'hA001, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
        exp_q.push_back(32'hA001);
        #1 chk("disp_not_same_cycle", {31'd0, issue_valid}, 32'd0);
        next_cycle(); #2;
        chk("single_free", 32'(free_cnt), 32'd7);
        chk("single_valid", {31'd0, issue_valid}, 32'd1);
        chk("single_dst", 32'(issue_dst), 32'd1);
        chk("single_no_bc_unready", {31'd0, own_bc_valid}, 32'd0);
        issue_ready = 1'b1;
        set_disp(1, 32'hA0FF, 6'd2, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
        exp_q.push_back(32'hA0FF);
        #1;
        chk("single_own_bc", {31'd0, own_bc_valid}, 32'd1);
        chk("single_own_dst", 32'(own_bc_dst), 32'd1);
        sb_check("single_issue");
        next_cycle(); #2;
        chk("reuse_free", 32'(free_cnt), 32'd7);
        chk("reuse_no_bc_wr0", {31'd0, own_bc_valid}, 32'd0);
        sb_check("reuse_issue");
        next_cycle(); #2;
        chk("single_freed", 32'(free_cnt), 32'd8);
        chk("single_empty", {31'd0, issue_valid}, 32'd0);

        // ALU chain: B waits on A's own broadcast
        set_disp(1, 32'hA002, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
        set_disp(2, 32'hB002, 6'd7, 1'b1, 1'b1, 6'd5, 1'b0, 4'b0000, 4'b1111);
        exp_q.push_back(32'hA002);
        exp_q.push_back(32'hB002);
        next_cycle(); #2;
        sb_check("alu_a");
        chk("alu_own_bc", {31'd0, own_bc_valid}, 32'd1);
        chk("alu_own_dst", 32'(own_bc_dst), 32'd5);
        next_cycle(); #2;
        sb_check("alu_b");
        chk("alu_b_dst", 32'(own_bc_dst), 32'd7);
        next_cycle(); #2;
        chk("alu_done", {31'd0, issue_valid}, 32'd0);

        // MUL latency: ready 3 cycles after broadcast
        set_disp(1, 32'hC003, 6'd10, 1'b1, 1'b1, 6'd9, 1'b0, 4'b0000, 4'b1100);
        exp_q.push_back(32'hC003);
        next_cycle();
        bc_valid_1 = 1'b1; bc_dst_1 = 6'd9;
        #2 chk("mul_t0", {31'd0, issue_valid}, 32'd0);
        next_cycle(); #2 chk("mul_t1", {31'd0, issue_valid}, 32'd0);
        next_cycle(); #2 chk("mul_t2", {31'd0, issue_valid}, 32'd0);
        next_cycle(); #2 sb_check("mul_t3");
        next_cycle(); #2 chk("mul_done", {31'd0, issue_valid}, 32'd0);

        // overflow: fill 7, then dual dispatch
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_disp(1, 32'hB100 + 32'(2 * k), 6'd20, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
            exp_q.push_back(32'hB100 + 32'(2 * k));
            if (k < 3) begin
                set_disp(2, 32'hB101 + 32'(2 * k), 6'd20, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
                exp_q.push_back(32'hB101 + 32'(2 * k));
            end
            next_cycle();
        end
        #2;
        chk("ovf_pre_free", 32'(free_cnt), 32'd1);
        chk("ovf_pre_flag", {31'd0, ovf}, 32'd0);
        set_disp(1, 32'hB1F0, 6'd20, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
        set_disp(2, 32'hB1F1, 6'd20, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
        exp_q.push_back(32'hB1F0);
        next_cycle(); #2;
        chk("ovf_free", 32'(free_cnt), 32'd0);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        issue_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            sb_check("ovf_drain");
            next_cycle(); #2;
        end
        chk("ovf_drained", {31'd0, issue_valid}, 32'd0);
        chk("ovf_drain_free", 32'(free_cnt), 32'd8);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // same-cycle bypass, then kill
        issue_ready = 1'b0;
        set_disp(1, 32'hD005, 6'd3, 1'b1, 1'b1, 6'd12, 1'b0, 4'b0000, 4'b1111);
        bc_valid_2 = 1'b1; bc_dst_2 = 6'd12;
        next_cycle(); #2;
        chk("bypass_ready", {31'd0, issue_valid}, 32'd1);
        chk("bypass_dst", 32'(issue_dst), 32'd3);
        kill = 1'b1;
        set_disp(1, 32'hE006, 6'd4, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
        next_cycle(); #2;
        chk("kill_free", 32'(free_cnt), 32'd8);
        chk("kill_valid", {31'd0, issue_valid}, 32'd0);
        chk("kill_keeps_ovf", {31'd0, ovf}, 32'd1);

        // select policy: entry 3 older than entry 1, both woken together
        set_disp(1, 32'hF000, 6'd11, 1'b1, 1'b1, 6'd20, 1'b0, 4'b0000, 4'b1111);
        set_disp(2, 32'hF001, 6'd12, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
        next_cycle();
        set_disp(1, 32'hF002, 6'd13, 1'b1, 1'b1, 6'd20, 1'b0, 4'b0000, 4'b1111);
        set_disp(2, 32'hF003, 6'd14, 1'b1, 1'b1, 6'd22, 1'b0, 4'b0000, 4'b1111);
        #2 chk("sel_free6", 32'(free_cnt), 32'd6);
        next_cycle();
        issue_ready = 1'b1;
        exp_q.push_back(32'hF001);
        #2 sb_check("sel_prep");
        next_cycle();
        issue_ready = 1'b0;
        set_disp(1, 32'hF0AA, 6'd15, 1'b1, 1'b1, 6'd22, 1'b0, 4'b0000, 4'b1111);
        #2;
        chk("sel_free5", 32'(free_cnt), 32'd5);
        chk("sel_none_ready", {31'd0, issue_valid}, 32'd0);
        next_cycle();
        bc_valid_1 = 1'b1; bc_dst_1 = 6'd22;
        #2 chk("sel_wait", {31'd0, issue_valid}, 32'd0);
        next_cycle();
        issue_ready = 1'b1;
`ifdef IQ_AGE_SELECT_EN
        exp_q.push_back(32'hF003);
        exp_q.push_back(32'hF0AA);
`else
        exp_q.push_back(32'hF0AA);
        exp_q.push_back(32'hF003);
`endif
        #2 sb_check("sel_first");
        next_cycle(); #2 sb_check("sel_second");
        next_cycle();
        bc_valid_1 = 1'b1; bc_dst_1 = 6'd20;
        #2 chk("sel_gap", {31'd0, issue_valid}, 32'd0);
        exp_q.push_back(32'hF000);
        exp_q.push_back(32'hF002);
        next_cycle(); #2 sb_check("sel_tail0");
        next_cycle(); #2 sb_check("sel_tail2");
        next_cycle(); #2;
        chk("end_valid", {31'd0, issue_valid}, 32'd0);
        chk("end_free", 32'(free_cnt), 32'd8);
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
